// File: rtl/pipe_pkg.sv
// Shared pipeline definitions.
// Holds the stall-vector encoding, the flow-control mode selectors, the stage
// index map, and the decode of a (producer, consumer) stall pair into the
// flow action taken by an inter-stage register.
package pipe_pkg;

   localparam int   STALL_W = 6;
   localparam logic Stop    = 1'b1;
   localparam logic NoStop  = 1'b0;

   localparam int MODE_STALL     = 0;
   localparam int MODE_HANDSHAKE = 1;

   localparam int PC  = 0;
   localparam int IF  = 1;
   localparam int ID  = 2;
   localparam int EX  = 3;
   localparam int MEM = 4;
   localparam int WB  = 5;

   typedef enum logic [1:0] {
      FLOW_ADVANCE = 2'd0,
      FLOW_BUBBLE  = 2'd1,
      FLOW_HOLD    = 2'd2
   } flow_e;

   // s = producer stall bit, c = consumer stall bit.
   // The illegal (NoStop, Stop) pair deliberately falls through to advance.
   function automatic flow_e decode_flow(input logic s, input logic c);
      flow_e f;
      case ({s, c})
         {Stop, NoStop}: f = FLOW_BUBBLE;
         {Stop, Stop}:   f = FLOW_HOLD;
         default:        f = FLOW_ADVANCE;
      endcase
      return f;
   endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Bundle of all non-clock signals of a pipe_stage_reg.
// master: the surrounding logic (drives payload/control, observes outputs).
// slave : the pipeline register itself.
interface pipe_stage_reg_if #(
   parameter int DATA_W  = 128,
   parameter int STALL_W = 6,
   parameter int CNT_W   = 16
);
   logic [STALL_W-1:0] stall;
   logic               flush;
   logic               in_valid;
   logic [DATA_W-1:0]  in_data;
   logic               in_next_ds;
   logic               in_ready;
   logic               out_valid;
   logic [DATA_W-1:0]  out_data;
   logic               out_ready;
   logic               ds_fb_o;
   logic [CNT_W-1:0]   bubble_cnt;
   logic [CNT_W-1:0]   hold_cnt;

   modport master (
      output stall, flush, in_valid, in_data, in_next_ds, out_ready,
      input  in_ready, out_valid, out_data, ds_fb_o, bubble_cnt, hold_cnt
   );

   modport slave (
      input  stall, flush, in_valid, in_data, in_next_ds, out_ready,
      output in_ready, out_valid, out_data, ds_fb_o, bubble_cnt, hold_cnt
   );
endinterface

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter for pipeline performance statistics.
// Ports: clk, rst (sync, active-high), inc (count enable), cnt (value,
// sticks at all-ones instead of wrapping).
module pipe_sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);
   logic [CNT_W-1:0] r_cnt;

   // Count register: clears on reset, increments until all-ones.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= {CNT_W{1'b0}};
      end else if (inc && (r_cnt != {CNT_W{1'b1}})) begin
         r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         r_cnt <= r_cnt;
      end
   end

   assign cnt = r_cnt;
endmodule

// File: rtl/pipe_stage_reg_chk.sv
// Simulation checker for pipe_stage_reg.
// Ports: clk, rst, stall (global stall vector).
// Flags the illegal stall pattern "producer runs while consumer stops" in
// stall-vector mode; the register itself advances regardless.
module pipe_stage_reg_chk #(
   parameter int STALL_W   = 6,
   parameter int STAGE_IDX = 2,
   parameter int MODE      = 0
) (
   input logic               clk,
   input logic               rst,
   input logic [STALL_W-1:0] stall
);
   import pipe_pkg::*;

   a_no_run_into_stopped_consumer: assert property (
      @(posedge clk) disable iff (rst)
         (MODE != MODE_STALL) ||
         !((stall[STAGE_IDX] == NoStop) && (stall[STAGE_IDX+1] == Stop))
   );
endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register.
// Ports: clk, rst (sync, active-high) and bus (pipe_stage_reg_if.slave):
//   stall/flush/in_valid/in_data/in_next_ds/out_ready in,
//   in_ready/out_valid/out_data/ds_fb_o/bubble_cnt/hold_cnt out.
// MODE_STALL: follows the global stall vector (advance / bubble / hold).
// MODE_HANDSHAKE: ready/valid with a main register plus one skid entry, so
// in_ready can be registered without losing throughput.
module pipe_stage_reg #(
   parameter int              DATA_W     = 128,
   parameter int              MODE       = 0,
   parameter int              STALL_W    = pipe_pkg::STALL_W,
   parameter int              STAGE_IDX  = 2,
   parameter logic [DATA_W-1:0] BUBBLE_VAL = {DATA_W{1'b0}},
   parameter int              CNT_W      = 16
) (
   input logic             clk,
   input logic             rst,
   pipe_stage_reg_if.slave bus
);
   import pipe_pkg::*;

   logic              r_out_valid, r_ds, r_skid_full, r_in_ready;
   logic [DATA_W-1:0] r_out_data, r_skid_data;

   logic              w_valid_nxt, w_ds_nxt, w_skid_full_nxt;
   logic [DATA_W-1:0] w_data_nxt, w_skid_data_nxt;
   logic              w_accept, w_bub_inc, w_hold_inc;
   flow_e             w_flow;

   assign w_flow   = decode_flow(bus.stall[STAGE_IDX], bus.stall[STAGE_IDX+1]);
   assign w_accept = bus.in_valid & r_in_ready;

   // Next-state and counter-increment selection; flush overrides flow control
   // and suppresses every other counter increment.
   always_comb begin
      w_valid_nxt     = r_out_valid;
      w_data_nxt      = r_out_data;
      w_ds_nxt        = r_ds;
      w_skid_data_nxt = r_skid_data;
      w_skid_full_nxt = r_skid_full;
      w_bub_inc       = 1'b0;
      w_hold_inc      = 1'b0;
      if (bus.flush) begin
         w_valid_nxt     = 1'b0;
         w_data_nxt      = BUBBLE_VAL;
         w_ds_nxt        = 1'b0;
         w_skid_full_nxt = 1'b0;
         w_bub_inc       = 1'b1;
      end else if (MODE == MODE_STALL) begin
         case (w_flow)
            FLOW_BUBBLE: begin
               w_valid_nxt = 1'b0;
               w_data_nxt  = BUBBLE_VAL;
               w_ds_nxt    = 1'b0;
               w_bub_inc   = 1'b1;
            end
            FLOW_HOLD: begin
               w_hold_inc = 1'b1;
            end
            default: begin
               w_valid_nxt = bus.in_valid;
               w_data_nxt  = bus.in_data;
               w_ds_nxt    = bus.in_next_ds;
            end
         endcase
      end else begin
         if (w_accept) begin
            w_ds_nxt = bus.in_next_ds;
         end else begin
            w_ds_nxt = r_ds;
         end
         if (!r_out_valid || bus.out_ready) begin
            // Main is free this cycle: older skid entry goes first to keep order.
            // A full skid implies in_ready=0, so no accept can collide here.
            if (r_skid_full) begin
               w_data_nxt      = r_skid_data;
               w_valid_nxt     = 1'b1;
               w_skid_full_nxt = 1'b0;
            end else if (w_accept) begin
               w_data_nxt  = bus.in_data;
               w_valid_nxt = 1'b1;
            end else begin
               w_valid_nxt = 1'b0;
            end
         end else begin
            if (w_accept) begin
               w_skid_data_nxt = bus.in_data;
               w_skid_full_nxt = 1'b1;
            end else begin
               w_skid_full_nxt = r_skid_full;
            end
         end
         w_hold_inc = r_out_valid & ~bus.out_ready;
         w_bub_inc  = ~r_out_valid;
      end
   end

   // Payload, flags, skid entry and registered in_ready.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_data  <= BUBBLE_VAL;
         r_ds        <= 1'b0;
         r_skid_full <= 1'b0;
         r_skid_data <= BUBBLE_VAL;
         r_in_ready  <= 1'b0;
      end else begin
         r_out_valid <= w_valid_nxt;
         r_out_data  <= w_data_nxt;
         r_ds        <= w_ds_nxt;
         r_skid_full <= w_skid_full_nxt;
         r_skid_data <= w_skid_data_nxt;
         r_in_ready  <= (MODE == MODE_STALL) ? 1'b1 : ~w_skid_full_nxt;
      end
   end

   pipe_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
      .clk (clk), .rst (rst), .inc (w_bub_inc),  .cnt (bus.bubble_cnt)
   );

   pipe_sat_counter #(.CNT_W(CNT_W)) u_hold_cnt (
      .clk (clk), .rst (rst), .inc (w_hold_inc), .cnt (bus.hold_cnt)
   );

   pipe_stage_reg_chk #(.STALL_W(STALL_W), .STAGE_IDX(STAGE_IDX), .MODE(MODE)) u_chk (
      .clk (clk), .rst (rst), .stall (bus.stall)
   );

   assign bus.in_ready  = r_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;
   assign bus.ds_fb_o   = r_ds;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: stall-vector instance (u_dut0),
// handshake instance (u_dut1) and a narrow-counter stall instance (u_dut2).
module tb_pipe_stage_reg;
   localparam logic [127:0] BUB = 128'h0BAD;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   pipe_stage_reg_if #(.DATA_W(128), .STALL_W(6), .CNT_W(16)) b0 ();
   pipe_stage_reg_if #(.DATA_W(128), .STALL_W(6), .CNT_W(16)) b1 ();
   pipe_stage_reg_if #(.DATA_W(128), .STALL_W(6), .CNT_W(4))  b2 ();

   pipe_stage_reg #(.DATA_W(128), .MODE(0), .STALL_W(6), .STAGE_IDX(2), .BUBBLE_VAL(BUB), .CNT_W(16))
      u_dut0 (.clk(clk), .rst(rst), .bus(b0));
   pipe_stage_reg #(.DATA_W(128), .MODE(1), .STALL_W(6), .STAGE_IDX(2), .BUBBLE_VAL(BUB), .CNT_W(16))
      u_dut1 (.clk(clk), .rst(rst), .bus(b1));
   pipe_stage_reg #(.DATA_W(128), .MODE(0), .STALL_W(6), .STAGE_IDX(2), .BUBBLE_VAL(BUB), .CNT_W(4))
      u_dut2 (.clk(clk), .rst(rst), .bus(b2));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic init_inputs();
      b0.stall = 6'b0; b0.flush = 1'b0; b0.in_valid = 1'b0; b0.in_data = 128'h0; b0.in_next_ds = 1'b0; b0.out_ready = 1'b0;
      b1.stall = 6'b0; b1.flush = 1'b0; b1.in_valid = 1'b0; b1.in_data = 128'h0; b1.in_next_ds = 1'b0; b1.out_ready = 1'b0;
      b2.stall = 6'b0; b2.flush = 1'b0; b2.in_valid = 1'b0; b2.in_data = 128'h0; b2.in_next_ds = 1'b0; b2.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      n_checks++; if (b0.out_valid !== 1'b0) begin n_errors++; $display("FAIL rst_valid: got %0b expected 0", b0.out_valid); end
      n_checks++; if (b0.out_data !== BUB) begin n_errors++; $display("FAIL rst_data: got %0h expected %0h", b0.out_data, BUB); end
      n_checks++; if (b0.ds_fb_o !== 1'b0) begin n_errors++; $display("FAIL rst_ds: got %0b expected 0", b0.ds_fb_o); end
      n_checks++; if (b0.bubble_cnt !== 16'd0) begin n_errors++; $display("FAIL rst_bubble: got %0d expected 0", b0.bubble_cnt); end
      n_checks++; if (b0.hold_cnt !== 16'd0) begin n_errors++; $display("FAIL rst_hold: got %0d expected 0", b0.hold_cnt); end
      n_checks++; if (b0.in_ready !== 1'b0) begin n_errors++; $display("FAIL rst_in_ready0: got %0b expected 0", b0.in_ready); end
      n_checks++; if (b1.in_ready !== 1'b0) begin n_errors++; $display("FAIL rst_in_ready1: got %0b expected 0", b1.in_ready); end
      rst = 1'b0;
      tick();
      n_checks++; if (b0.in_ready !== 1'b1) begin n_errors++; $display("FAIL post_rst_in_ready0: got %0b expected 1", b0.in_ready); end
      n_checks++; if (b1.in_ready !== 1'b1) begin n_errors++; $display("FAIL post_rst_in_ready1: got %0b expected 1", b1.in_ready); end
   endtask

   task automatic test_advance();
      b0.stall = 6'b000000; b0.in_data = 128'hA5; b0.in_valid = 1'b1; b0.in_next_ds = 1'b1;
      tick();
      n_checks++; if (b0.out_data !== 128'hA5) begin n_errors++; $display("FAIL adv_data: got %0h expected a5", b0.out_data); end
      n_checks++; if (b0.out_valid !== 1'b1) begin n_errors++; $display("FAIL adv_valid: got %0b expected 1", b0.out_valid); end
      n_checks++; if (b0.ds_fb_o !== 1'b1) begin n_errors++; $display("FAIL adv_ds: got %0b expected 1", b0.ds_fb_o); end
   endtask

   task automatic test_bubble_hold();
      b0.stall = 6'b000100; b0.in_data = 128'h77;
      tick();
      n_checks++; if (b0.out_valid !== 1'b0) begin n_errors++; $display("FAIL bub_valid: got %0b expected 0", b0.out_valid); end
      n_checks++; if (b0.out_data !== BUB) begin n_errors++; $display("FAIL bub_data: got %0h expected %0h", b0.out_data, BUB); end
      n_checks++; if (b0.ds_fb_o !== 1'b0) begin n_errors++; $display("FAIL bub_ds: got %0b expected 0", b0.ds_fb_o); end
      n_checks++; if (b0.bubble_cnt !== 16'd1) begin n_errors++; $display("FAIL bub_cnt: got %0d expected 1", b0.bubble_cnt); end
      // load a valid payload so the hold has something visible to freeze
      b0.stall = 6'b000000; b0.in_data = 128'h3C; b0.in_valid = 1'b1; b0.in_next_ds = 1'b1;
      tick();
      n_checks++; if (b0.out_data !== 128'h3C) begin n_errors++; $display("FAIL load_data: got %0h expected 3c", b0.out_data); end
      b0.stall = 6'b001100; b0.in_data = 128'h77; b0.in_valid = 1'b0; b0.in_next_ds = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++; if (b0.out_data !== 128'h3C) begin n_errors++; $display("FAIL hold_data[%0d]: got %0h expected 3c", i, b0.out_data); end
         n_checks++; if (b0.ds_fb_o !== 1'b1 || b0.out_valid !== 1'b1) begin n_errors++; $display("FAIL hold_flags[%0d]: got ds=%0b v=%0b expected 1 1", i, b0.ds_fb_o, b0.out_valid); end
      end
      n_checks++; if (b0.hold_cnt !== 16'd3) begin n_errors++; $display("FAIL hold_cnt: got %0d expected 3", b0.hold_cnt); end
      n_checks++; if (b0.bubble_cnt !== 16'd1) begin n_errors++; $display("FAIL hold_bub_cnt: got %0d expected 1", b0.bubble_cnt); end
   endtask

   task automatic test_flush();
      b0.stall = 6'b000000; b0.flush = 1'b1; b0.in_data = 128'h55; b0.in_valid = 1'b1; b0.in_next_ds = 1'b1;
      tick();
      n_checks++; if (b0.out_valid !== 1'b0) begin n_errors++; $display("FAIL fl_valid: got %0b expected 0", b0.out_valid); end
      n_checks++; if (b0.out_data !== BUB) begin n_errors++; $display("FAIL fl_data: got %0h expected %0h", b0.out_data, BUB); end
      n_checks++; if (b0.ds_fb_o !== 1'b0) begin n_errors++; $display("FAIL fl_ds: got %0b expected 0", b0.ds_fb_o); end
      n_checks++; if (b0.bubble_cnt !== 16'd2) begin n_errors++; $display("FAIL fl_bub_cnt: got %0d expected 2", b0.bubble_cnt); end
      b0.flush = 1'b0; b0.in_data = 128'h66;
      tick();
      n_checks++; if (b0.out_data !== 128'h66 || b0.out_valid !== 1'b1) begin n_errors++; $display("FAIL fl_resume: got %0h/%0b expected 66/1", b0.out_data, b0.out_valid); end
      // flush during a hold: only the bubble counter moves
      b0.flush = 1'b1; b0.stall = 6'b001100;
      tick();
      n_checks++; if (b0.out_data !== BUB) begin n_errors++; $display("FAIL flhold_data: got %0h expected %0h", b0.out_data, BUB); end
      n_checks++; if (b0.bubble_cnt !== 16'd3) begin n_errors++; $display("FAIL flhold_bub: got %0d expected 3", b0.bubble_cnt); end
      n_checks++; if (b0.hold_cnt !== 16'd3) begin n_errors++; $display("FAIL flhold_hold: got %0d expected 3", b0.hold_cnt); end
      b0.flush = 1'b0; b0.stall = 6'b000000; b0.in_valid = 1'b0;
   endtask

   task automatic test_back_to_back();
      b1.out_ready = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         b1.in_valid = 1'b1; b1.in_data = 128'(k);
         tick();
         n_checks++; if (b1.out_data !== 128'(k) || b1.out_valid !== 1'b1) begin n_errors++; $display("FAIL stream[%0d]: got %0h/%0b expected %0h/1", k, b1.out_data, b1.out_valid, k); end
         n_checks++; if (b1.in_ready !== 1'b1) begin n_errors++; $display("FAIL stream_rdy[%0d]: got %0b expected 1", k, b1.in_ready); end
      end
      b1.in_valid = 1'b0;
      tick();
      n_checks++; if (b1.out_valid !== 1'b0) begin n_errors++; $display("FAIL stream_drain: got %0b expected 0", b1.out_valid); end
   endtask

   task automatic test_skid();
      b1.out_ready = 1'b0;
      b1.in_valid = 1'b1; b1.in_data = 128'd1; b1.in_next_ds = 1'b0;
      tick();
      n_checks++; if (b1.out_data !== 128'd1 || b1.in_ready !== 1'b1) begin n_errors++; $display("FAIL skid_c1: got %0h/rdy%0b expected 1/rdy1", b1.out_data, b1.in_ready); end
      b1.in_data = 128'd2; b1.in_next_ds = 1'b1;
      tick();
      n_checks++; if (b1.out_data !== 128'd1 || b1.in_ready !== 1'b0) begin n_errors++; $display("FAIL skid_c2: got %0h/rdy%0b expected 1/rdy0", b1.out_data, b1.in_ready); end
      n_checks++; if (b1.ds_fb_o !== 1'b1) begin n_errors++; $display("FAIL skid_ds2: got %0b expected 1", b1.ds_fb_o); end
      b1.in_data = 128'd3; b1.in_next_ds = 1'b0;
      tick();
      n_checks++; if (b1.out_data !== 128'd1 || b1.in_ready !== 1'b0) begin n_errors++; $display("FAIL skid_c3: got %0h/rdy%0b expected 1/rdy0", b1.out_data, b1.in_ready); end
      n_checks++; if (b1.ds_fb_o !== 1'b1) begin n_errors++; $display("FAIL skid_ds3: got %0b expected 1", b1.ds_fb_o); end
      n_checks++; if (b1.hold_cnt !== 16'd2) begin n_errors++; $display("FAIL skid_hold: got %0d expected 2", b1.hold_cnt); end
      b1.out_ready = 1'b1;
      tick();
      n_checks++; if (b1.out_data !== 128'd2 || b1.out_valid !== 1'b1 || b1.in_ready !== 1'b1) begin n_errors++; $display("FAIL skid_rel2: got %0h/v%0b/rdy%0b expected 2/v1/rdy1", b1.out_data, b1.out_valid, b1.in_ready); end
      tick();
      n_checks++; if (b1.out_data !== 128'd3 || b1.out_valid !== 1'b1) begin n_errors++; $display("FAIL skid_rel3: got %0h/v%0b expected 3/v1", b1.out_data, b1.out_valid); end
      n_checks++; if (b1.ds_fb_o !== 1'b0) begin n_errors++; $display("FAIL skid_ds_rel3: got %0b expected 0", b1.ds_fb_o); end
      b1.in_valid = 1'b0;
      tick();
      n_checks++; if (b1.out_valid !== 1'b0) begin n_errors++; $display("FAIL skid_empty: got %0b expected 0", b1.out_valid); end
   endtask

   task automatic test_saturate();
      b2.stall = 6'b000000; b2.in_data = 128'h99; b2.in_valid = 1'b1; b2.in_next_ds = 1'b1;
      tick();
      b2.stall = 6'b001100; b2.in_data = 128'h11; b2.in_valid = 1'b0; b2.in_next_ds = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (i == 14) begin
            n_checks++; if (b2.hold_cnt !== 4'd14) begin n_errors++; $display("FAIL sat_14: got %0d expected 14", b2.hold_cnt); end
         end
         if (i == 20) begin
            n_checks++; if (b2.hold_cnt !== 4'd15) begin n_errors++; $display("FAIL sat_20: got %0d expected 15", b2.hold_cnt); end
            n_checks++; if (b2.out_data !== 128'h99) begin n_errors++; $display("FAIL sat_data: got %0h expected 99", b2.out_data); end
         end
      end
      rst = 1'b1;
      tick();
      n_checks++; if (b2.out_valid !== 1'b0 || b2.ds_fb_o !== 1'b0) begin n_errors++; $display("FAIL srst_flags: got v%0b ds%0b expected 0 0", b2.out_valid, b2.ds_fb_o); end
      n_checks++; if (b2.out_data !== BUB) begin n_errors++; $display("FAIL srst_data: got %0h expected %0h", b2.out_data, BUB); end
      n_checks++; if (b2.hold_cnt !== 4'd0 || b2.bubble_cnt !== 4'd0) begin n_errors++; $display("FAIL srst_cnt: got h%0d b%0d expected 0 0", b2.hold_cnt, b2.bubble_cnt); end
      n_checks++; if (b2.in_ready !== 1'b0) begin n_errors++; $display("FAIL srst_rdy: got %0b expected 0", b2.in_ready); end
      rst = 1'b0;
      b2.stall = 6'b000000;
      tick();
   endtask

   initial begin
      init_inputs();
      test_reset();
      test_advance();
      test_bubble_hold();
      test_flush();
      test_back_to_back();
      test_skid();
      test_saturate();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
